// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter sharing one bank of JK cells between NREQ requesters,
// with a two-phase capture/commit FSM. Optional toggle counter: JK_TOGGLE_CNT_EN.
module jk_bank_arbiter #(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned NBITS = 8,
   parameter int unsigned IDXW  = 3
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NREQ-1:0]        req,
   input  logic [2*NREQ-1:0]      cmd_jk,
   input  logic [IDXW*NREQ-1:0]   cmd_idx,
   output logic [NREQ-1:0]        gnt,
   output logic                   busy,
   output logic                   done,
   output logic [2:0]             done_id,
   output logic                   err,
   output logic [NBITS-1:0]       q,
`ifdef JK_TOGGLE_CNT_EN
   output logic [7:0]             tgl_cnt,
`endif
   output logic [NBITS-1:0]       q_bar
);

   localparam int unsigned PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic {S_IDLE = 1'b0, S_COMMIT = 1'b1} state_t;

   typedef struct packed {
      logic [1:0]      jk;
      logic [IDXW-1:0] idx;
      logic [PTRW-1:0] id;
   } cmd_t;

   state_t           r_state, w_state_nxt;
   logic [PTRW-1:0]  r_ptr, w_ptr_nxt;
   cmd_t             r_m, w_m_nxt;
   logic [NREQ-1:0]  r_gnt, w_gnt_nxt;
   logic             r_busy, w_busy_nxt;
   logic             r_done, w_done_nxt;
   logic             r_err, w_err_nxt;
   logic [2:0]       r_done_id, w_done_id_nxt;
   logic [NBITS-1:0] r_q, w_q_nxt;
   logic             w_tgl_inc;

   logic             w_found;
   logic [PTRW-1:0]  w_win;
   cmd_t             w_sel;
   logic             w_in_range;
   logic [NBITS-1:0] w_mask;

   // Winner is the first pending request at distance 0..NREQ-1 from the pointer
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_sel   = '0;
      for (int k = 0; k < NREQ; k++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!w_found && req[i] &&
                (PTRW'((32'(r_ptr) + 32'(k)) % NREQ) == PTRW'(i))) begin
               w_found   = 1'b1;
               w_win     = PTRW'(i);
               w_sel.jk  = cmd_jk[2*i +: 2];
               w_sel.idx = cmd_idx[IDXW*i +: IDXW];
               w_sel.id  = PTRW'(i);
            end
         end
      end
   end

   assign w_in_range = (32'(r_m.idx) < NBITS);
   assign w_mask     = NBITS'(1) << r_m.idx;

   always_comb begin
      w_state_nxt   = r_state;
      w_ptr_nxt     = r_ptr;
      w_m_nxt       = r_m;
      w_gnt_nxt     = '0;
      w_busy_nxt    = 1'b0;
      w_done_nxt    = 1'b0;
      w_err_nxt     = 1'b0;
      w_done_id_nxt = r_done_id;
      w_q_nxt       = r_q;
      w_tgl_inc     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_found) begin
               w_m_nxt     = w_sel;
               w_gnt_nxt   = NREQ'(1) << w_win;
               w_busy_nxt  = 1'b1;
               w_ptr_nxt   = PTRW'((32'(w_win) + 32'd1) % NREQ);
               w_state_nxt = S_COMMIT;
            end
         end
         S_COMMIT: begin
            if (w_in_range) begin
               case (r_m.jk)
                  2'b01:   w_q_nxt = r_q & ~w_mask;
                  2'b10:   w_q_nxt = r_q | w_mask;
                  2'b11: begin
                     w_q_nxt   = r_q ^ w_mask;
                     w_tgl_inc = 1'b1;
                  end
                  default: w_q_nxt = r_q;
               endcase
            end else begin
               w_err_nxt = 1'b1;
            end
            w_done_nxt    = 1'b1;
            w_done_id_nxt = 3'(r_m.id);
            w_state_nxt   = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_ptr     <= '0;
         r_m       <= '0;
         r_gnt     <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         r_done_id <= '0;
         r_q       <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_ptr     <= w_ptr_nxt;
         r_m       <= w_m_nxt;
         r_gnt     <= w_gnt_nxt;
         r_busy    <= w_busy_nxt;
         r_done    <= w_done_nxt;
         r_err     <= w_err_nxt;
         r_done_id <= w_done_id_nxt;
         r_q       <= w_q_nxt;
      end
   end

`ifdef JK_TOGGLE_CNT_EN
   logic [7:0] r_tgl_cnt;

   // Saturating count of in-range toggle commits
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tgl_cnt <= '0;
      end else if (w_tgl_inc && (r_tgl_cnt != 8'hFF)) begin
         r_tgl_cnt <= r_tgl_cnt + 8'd1;
      end
   end

   assign tgl_cnt = r_tgl_cnt;
`else
   logic w_unused_tgl;
   assign w_unused_tgl = w_tgl_inc;
`endif

   assign gnt     = r_gnt;
   assign busy    = r_busy;
   assign done    = r_done;
   assign done_id = r_done_id;
   assign err     = r_err;
   assign q       = r_q;
   assign q_bar   = ~r_q;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Directed bench for jk_bank_arbiter (NREQ=4, NBITS=8, IDXW=4 so idx>=8 is out of range).
module tb_jk_bank_arbiter;

   localparam int unsigned NREQ  = 4;
   localparam int unsigned NBITS = 8;
   localparam int unsigned IDXW  = 4;

   logic                 clk;
   logic                 rst_n;
   logic [NREQ-1:0]      req;
   logic [2*NREQ-1:0]    cmd_jk;
   logic [IDXW*NREQ-1:0] cmd_idx;
   logic [NREQ-1:0]      gnt;
   logic                 busy;
   logic                 done;
   logic [2:0]           done_id;
   logic                 err;
   logic [NBITS-1:0]     q;
   logic [NBITS-1:0]     q_bar;
`ifdef JK_TOGGLE_CNT_EN
   logic [7:0]           tgl_cnt;
`endif

   int total = 0;
   int bad   = 0;

   jk_bank_arbiter #(.NREQ(NREQ), .NBITS(NBITS), .IDXW(IDXW)) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .cmd_jk  (cmd_jk),
      .cmd_idx (cmd_idx),
      .gnt     (gnt),
      .busy    (busy),
      .done    (done),
      .done_id (done_id),
      .err     (err),
      .q       (q),
`ifdef JK_TOGGLE_CNT_EN
      .tgl_cnt (tgl_cnt),
`endif
      .q_bar   (q_bar)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_cmd(input int r, input logic [1:0] jk, input logic [IDXW-1:0] idx);
      cmd_jk[2*r +: 2]     = jk;
      cmd_idx[IDXW*r +: 4] = idx;
   endtask

   logic [NBITS-1:0] exp_q;
   int               exp_id;

   initial begin
      rst_n   = 1'b0;
      req     = '0;
      cmd_jk  = '0;
      cmd_idx = '0;
      #12;
      chk("rst_q",     32'(q),       32'h00);
      chk("rst_qbar",  32'(q_bar),   32'hFF);
      chk("rst_gnt",   32'(gnt),     32'h0);
      chk("rst_busy",  32'(busy),    32'h0);
      chk("rst_done",  32'(done),    32'h0);
      chk("rst_id",    32'(done_id), 32'h0);
      chk("rst_err",   32'(err),     32'h0);
      #3 rst_n = 1'b1;
      tick();

      // single set: requester 1, {1,0}, idx 5
      set_cmd(1, 2'b10, 4'd5);
      req = 4'b0010;
      tick();
      chk("set_gnt",  32'(gnt),  32'b0010);
      chk("set_busy", 32'(busy), 32'h1);
      chk("set_q_e0", 32'(q),    32'h00);
      chk("set_done_e0", 32'(done), 32'h0);
      req = '0;
      tick();
      chk("set_q",    32'(q),       32'h20);
      chk("set_qbar", 32'(q_bar),   32'hDF);
      chk("set_done", 32'(done),    32'h1);
      chk("set_id",   32'(done_id), 32'd1);
      chk("set_gnt1", 32'(gnt),     32'h0);
      chk("set_busy1", 32'(busy),   32'h0);
      chk("set_err",  32'(err),     32'h0);
      tick();
      chk("set_done_pulse", 32'(done), 32'h0);

      // toggle same cell back to 0 (pointer is 2, requester 1 still wins alone)
      set_cmd(1, 2'b11, 4'd5);
      req = 4'b0010;
      tick();
      chk("tgl_gnt", 32'(gnt), 32'b0010);
      req = '0;
      tick();
      chk("tgl_q",    32'(q),    32'h00);
      chk("tgl_done", 32'(done), 32'h1);

      // set bit 7 via requester 3 (pointer 2 -> winner 3, pointer wraps to 0)
      set_cmd(3, 2'b10, 4'd7);
      req = 4'b1000;
      tick();
      chk("s7_gnt", 32'(gnt), 32'b1000);
      req = '0;
      tick();
      chk("s7_q",  32'(q),       32'h80);
      chk("s7_id", 32'(done_id), 32'd3);

      // reset while in COMMIT: commit dropped, q cleared, no done
      set_cmd(2, 2'b10, 4'd6);
      req = 4'b0100;
      tick();
      chk("mr_gnt",  32'(gnt),  32'b0100);
      chk("mr_busy", 32'(busy), 32'h1);
      req = '0;
      #2 rst_n = 1'b0;
      #1;
      chk("mr_q",    32'(q),     32'h00);
      chk("mr_qbar", 32'(q_bar), 32'hFF);
      chk("mr_gnt0", 32'(gnt),   32'h0);
      chk("mr_busy0", 32'(busy), 32'h0);
      chk("mr_done0", 32'(done), 32'h0);
      #1 rst_n = 1'b1;
      tick();
      chk("mr_nodone", 32'(done), 32'h0);
      chk("mr_q_after", 32'(q),   32'h00);

      // contention: all four toggle distinct cells; pointer restarted at 0
      for (int i = 0; i < 4; i++) set_cmd(i, 2'b11, 4'(i));
      req   = 4'b1111;
      exp_q = '0;
      for (int g = 0; g < 4; g++) begin
         tick();
         chk($sformatf("ct_gnt%0d", g), 32'(gnt), 32'(1) << g);
         req[g] = 1'b0;
         tick();
         exp_q[g] = 1'b1;
         chk($sformatf("ct_done%0d", g), 32'(done),    32'h1);
         chk($sformatf("ct_id%0d", g),   32'(done_id), 32'(g));
         chk($sformatf("ct_q%0d", g),    32'(q),       32'(exp_q));
      end
      chk("ct_final_q", 32'(q), 32'h0F);

      // fairness: req0 held, req2 asserted, both hold commands -> 0,2,0,2,...
      set_cmd(0, 2'b00, 4'd0);
      set_cmd(2, 2'b00, 4'd2);
      req = 4'b0101;
      for (int n = 0; n < 6; n++) begin
         exp_id = (n % 2 == 0) ? 0 : 2;
         tick();
         chk($sformatf("rr_gnt%0d", n), 32'(gnt), 32'(1) << exp_id);
         tick();
         chk($sformatf("rr_id%0d", n), 32'(done_id), 32'(exp_id));
      end
      req = '0;
      tick();
      chk("rr_q", 32'(q), 32'h0F);
`ifdef JK_TOGGLE_CNT_EN
      chk("tc_after_hold", 32'(tgl_cnt), 32'd4);
`endif

      // out of range: idx 9 set, then idx 8 toggle (exactly NBITS)
      set_cmd(1, 2'b10, 4'd9);
      req = 4'b0010;
      tick();
      chk("oor_gnt", 32'(gnt), 32'b0010);
      req = '0;
      tick();
      chk("oor_done", 32'(done), 32'h1);
      chk("oor_err",  32'(err),  32'h1);
      chk("oor_q",    32'(q),    32'h0F);
      chk("oor_id",   32'(done_id), 32'd1);
      tick();
      chk("oor_err_pulse", 32'(err), 32'h0);
      set_cmd(1, 2'b11, 4'd8);
      req = 4'b0010;
      tick();
      req = '0;
      tick();
      chk("oor8_err", 32'(err), 32'h1);
      chk("oor8_q",   32'(q),   32'h0F);
`ifdef JK_TOGGLE_CNT_EN
      chk("tc_after_oor", 32'(tgl_cnt), 32'd4);
      // saturation: 300 in-range toggles
      set_cmd(0, 2'b11, 4'd7);
      for (int n = 0; n < 300; n++) begin
         req = 4'b0001;
         tick();
         req = '0;
         tick();
      end
      chk("tc_sat", 32'(tgl_cnt), 32'd255);
      chk("tc_q",   32'(q),       32'h0F);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/jk_bank_arbiter.md
Name: jk_bank_arbiter

Overview:
- Shares one bank of NBITS JK flip-flop cells between NREQ requesters.
- Each requester posts one JK command (hold/reset/set/toggle) aimed at a single cell index.
- A round-robin arbiter picks one winner. A two-phase master/slave FSM captures the winner's command in the master stage, then commits it to the slave bank.
- Sits between control agents and the shared JK state register.

Parameters:
- NREQ, 4, number of requesters (2..8)
- NBITS, 8, number of JK cells in the bank
- IDXW, 3, cell-index width per requester; must be >= clog2(NBITS)

Ports:
- clk  input  1  single clock, rising-edge
- rst_n  input  1  asynchronous active-low reset
- req  input  NREQ  per-requester request, held until granted
- cmd_jk  input  2*NREQ  {j,k} for requester i at bits [2i+1:2i]
- cmd_idx  input  IDXW*NREQ  target cell for requester i at bits [IDXW*i +: IDXW]
- gnt  output  NREQ  one-hot grant, registered, one-cycle pulse
- busy  output  1  high while FSM is in COMMIT
- done  output  1  one-cycle pulse, command committed
- done_id  output  3  index of the requester whose command committed; valid with done
- err  output  1  one-cycle pulse with done when the committed index was >= NBITS
- q  output  NBITS  slave bank state
- q_bar  output  NBITS  bitwise ~q, combinational

Behaviour:
- Reset (async, rst_n=0): state=IDLE, q=0 (q_bar=all ones), gnt=0, busy=0, done=0, done_id=0, err=0, rr_ptr=0, master regs cleared. Any captured but uncommitted command is discarded.
- FSM has two states, IDLE and COMMIT.
- IDLE, req==0: stay in IDLE; outputs idle.
- IDLE, req!=0, at edge E0:
  - Winner = first set req bit searching rr_ptr, rr_ptr+1, ... modulo NREQ.
  - Master regs <= winner's {j,k}, idx and id.
  - gnt <= onehot(winner), busy<=1, state<=COMMIT.
  - rr_ptr <= (winner+1) mod NREQ.
- COMMIT, at edge E1, master command applied to q[idx]:
  - 00: hold
  - 01: q[idx]<=0
  - 10: q[idx]<=1
  - 11: q[idx]<=~q[idx]
  - All other cells unchanged.
  - If idx>=NBITS, q is unchanged and err<=1.
  - Also: done<=1, done_id<=id, gnt<=0, busy<=0, state<=IDLE.
- done and err are high for exactly the cycle after E1.
- Latency: req sampled at E0 -> q updated at E1 (1 cycle). Throughput is one command per 2 cycles.
- req is ignored during COMMIT.
- Requester handshake: sample gnt at E1, then drop req or present the next command before E2. E2 re-arbitrates with the already-advanced pointer.
- cmd_jk and cmd_idx must be stable while req is high. They are sampled only at the arbitration edge; later changes do not affect the committed command.
- Simultaneous requests: only the winner is granted. The others stay pending and win in later IDLE cycles in round-robin order, so no requester waits more than NREQ arbitrations.
- rst_n asserted in COMMIT: q cleared, the commit is dropped, and no done pulse is produced.

Optional Feature:
- Macro: JK_TOGGLE_CNT_EN.
- With the macro: adds output tgl_cnt (8 bits). It increments on every commit with {j,k}=11 and idx<NBITS, saturates at 255, and resets to 0.
- Without the macro: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: assert rst_n=0 mid-operation -> q=8'h00, q_bar=8'hFF, gnt=0, done=0 immediately; pointer restarts at 0.
- Single set/toggle:
  - req[1]=1, cmd {1,0} idx 5 -> gnt=4'b0010 one cycle, then q=8'h20, done=1, done_id=1.
  - Repeat with {1,1} -> q=8'h00.
- Contention: req=4'b1111, all {1,1} on distinct idx 0..3, each req dropped after its gnt -> grants in order 0,1,2,3, one every 2 cycles; final q=8'h0F.
- Round-robin fairness: req[0] held continuously plus req[2] asserted -> grant order 0,2,0,2,...; neither requester is starved.
- Out-of-range: NBITS=6, idx=7, cmd {1,0} -> err=1 with done; q unchanged.
- Optional feature (JK_TOGGLE_CNT_EN): 300 toggle commits -> tgl_cnt=255. Hold commands and out-of-range toggles leave tgl_cnt unchanged.
